// File: rtl/cfu_mac_sequencer.sv
// rtl/cfu_mac_sequencer.sv - sequences set-offset, clear and accumulate commands to a CFU MAC per job
// One MAC command is outstanding at a time; the last accumulate/clear response is the job result.
module cfu_mac_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_job_valid,
    output logic             o_job_ready,
    input  logic [31:0]      i_job_offset,
    input  logic [LEN_W-1:0] i_job_len,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [15:0]      i_op_data,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [31:0]      o_res_data,
    output logic             o_cfu_cmd_valid,
    input  logic             i_cfu_cmd_ready,
    output logic [9:0]       o_cfu_function_id,
    output logic [31:0]      o_cfu_inputs_0,
    output logic [31:0]      o_cfu_inputs_1,
    input  logic             i_cfu_rsp_valid,
    output logic             o_cfu_rsp_ready,
    input  logic [31:0]      i_cfu_rsp_data,
    output logic             o_busy,
    output logic [15:0]      o_jobs_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_OFS_CMD, S_OFS_RSP, S_CLR_CMD, S_CLR_RSP, S_ACC_CMD, S_ACC_RSP, S_DONE
    } state_t;

    localparam logic [9:0] FN_SET_OFS = 10'h013;
    localparam logic [9:0] FN_CLEAR   = 10'h00B;
    localparam logic [9:0] FN_MAC     = 10'h003;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_offset;
    logic [LEN_W-1:0] r_remaining;
    logic [31:0]      r_result;
    logic [15:0]      r_jobs_done;

    logic w_job_hs;
    logic w_cmd_hs;
    logic w_rsp_hs;
    logic w_res_hs;
    logic w_rem_zero;

    assign w_job_hs   = i_job_valid && o_job_ready;
    assign w_cmd_hs   = o_cfu_cmd_valid && i_cfu_cmd_ready;
    assign w_rsp_hs   = i_cfu_rsp_valid && o_cfu_rsp_ready;
    assign w_res_hs   = o_res_valid && i_res_ready;
    assign w_rem_zero = (r_remaining == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_job_hs) w_next = S_OFS_CMD;
            S_OFS_CMD: if (w_cmd_hs) w_next = S_OFS_RSP;
            S_OFS_RSP: if (w_rsp_hs) w_next = S_CLR_CMD;
            S_CLR_CMD: if (w_cmd_hs) w_next = S_CLR_RSP;
            S_CLR_RSP: if (w_rsp_hs) w_next = w_rem_zero ? S_DONE : S_ACC_CMD;
            S_ACC_CMD: if (w_cmd_hs) w_next = S_ACC_RSP;
            S_ACC_RSP: if (w_rsp_hs) w_next = w_rem_zero ? S_DONE : S_ACC_CMD;
            S_DONE:    if (w_res_hs) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // job_ready is gated by reset so it stays low while reset is held.
    always_comb begin
        o_job_ready       = 1'b0;
        o_op_ready        = 1'b0;
        o_res_valid       = 1'b0;
        o_cfu_cmd_valid   = 1'b0;
        o_cfu_function_id = 10'h000;
        o_cfu_inputs_0    = 32'h0;
        o_cfu_inputs_1    = 32'h0;
        o_cfu_rsp_ready   = 1'b0;
        case (r_state)
            S_IDLE: o_job_ready = i_rst_n;
            S_OFS_CMD: begin
                o_cfu_cmd_valid   = 1'b1;
                o_cfu_function_id = FN_SET_OFS;
                o_cfu_inputs_0    = r_offset;
            end
            S_CLR_CMD: begin
                o_cfu_cmd_valid   = 1'b1;
                o_cfu_function_id = FN_CLEAR;
            end
            S_ACC_CMD: begin
                o_cfu_cmd_valid   = i_op_valid;
                o_op_ready        = i_cfu_cmd_ready;
                o_cfu_function_id = FN_MAC;
                o_cfu_inputs_0    = {24'h0, i_op_data[15:8]};
                o_cfu_inputs_1    = {24'h0, i_op_data[7:0]};
            end
            S_OFS_RSP, S_CLR_RSP, S_ACC_RSP: o_cfu_rsp_ready = 1'b1;
            S_DONE: o_res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_offset    <= 32'h0;
            r_remaining <= '0;
            r_result    <= 32'h0;
            r_jobs_done <= 16'h0;
        end else begin
            if (w_job_hs) begin
                r_offset    <= i_job_offset;
                r_remaining <= i_job_len;
            end
            if (r_state == S_ACC_CMD && w_cmd_hs) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end
            if (w_rsp_hs && r_state != S_OFS_RSP) begin
                r_result <= i_cfu_rsp_data;
            end
            if (w_res_hs) begin
                r_jobs_done <= r_jobs_done + 16'd1;
            end
        end
    end

    assign o_res_data  = r_result;
    assign o_busy      = (r_state != S_IDLE);
    assign o_jobs_done = r_jobs_done;

endmodule

// File: tb/tb_cfu_mac_sequencer.sv
// tb/tb_cfu_mac_sequencer.sv - directed bench for cfu_mac_sequencer with a behavioural CFU MAC
module tb_cfu_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid, job_ready;
    logic [31:0] job_offset;
    logic [7:0]  job_len;
    logic        op_valid, op_ready;
    logic [15:0] op_data;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        cmd_valid, cmd_ready;
    logic [9:0]  fid;
    logic [31:0] in0, in1;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
    logic [15:0] jobs_done;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_jobs = 0;

    logic [15:0] ops [256];
    logic [9:0]  cmd_log [$];
    logic [31:0] mac_off = 32'hDEAD_BEEF;
    logic [31:0] mac_acc = 32'h1234_5678;
    bit tog_op, stall_cmd, hold_res;

    always #5 clk = ~clk;

    cfu_mac_sequencer #(.LEN_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_job_valid(job_valid), .o_job_ready(job_ready),
        .i_job_offset(job_offset), .i_job_len(job_len),
        .i_op_valid(op_valid), .o_op_ready(op_ready), .i_op_data(op_data),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
        .o_cfu_cmd_valid(cmd_valid), .i_cfu_cmd_ready(cmd_ready),
        .o_cfu_function_id(fid), .o_cfu_inputs_0(in0), .o_cfu_inputs_1(in1),
        .i_cfu_rsp_valid(rsp_valid), .o_cfu_rsp_ready(rsp_ready), .i_cfu_rsp_data(rsp_data),
        .o_busy(busy), .o_jobs_done(jobs_done)
    );

    function automatic logic [31:0] mac_term(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] off);
        int f, x;
        f = $signed(a[7:0]);
        x = $signed(b[7:0]);
        return 32'(f * (x + int'(off)));
    endfunction

    // MAC: acc += filter * (input + offset); responds the cycle after each command.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
        end else begin
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
            if (cmd_valid && cmd_ready) begin
                rsp_valid <= 1'b1;
                cmd_log.push_back(fid);
                case (fid)
                    10'h013: begin mac_off <= in0; rsp_data <= 32'hFFFF_FFFF; end
                    10'h00B: begin mac_acc <= 32'h0; rsp_data <= 32'h0; end
                    10'h003: begin
                        mac_acc  <= mac_acc + mac_term(in0, in1, mac_off);
                        rsp_data <= mac_acc + mac_term(in0, in1, mac_off);
                    end
                    default: rsp_data <= 32'hBAD0_BAD0;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_job(input logic [31:0] off, input int len,
                           output logic [31:0] res, output int lat, output int opr);
        int idx, hold, stalls, cyc;
        logic done;
        logic [31:0] first;
        @(negedge clk);
        job_valid = 1'b1; job_offset = off; job_len = len[7:0];
        #1;
        cyc = 0;
        while (!job_ready && cyc < 50) begin
            @(negedge clk); #1; cyc++;
        end
        check("job_accept", {31'h0, job_ready}, 32'd1);
        cmd_log.delete();
        idx = 0; done = 1'b0; lat = 0; opr = 0; hold = 0; stalls = 0; res = 32'h0; first = 32'h0;
        for (cyc = 1; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            job_valid = 1'b0;
            op_valid  = (idx < len) && (!tog_op || cyc[0]);
            op_data   = ops[idx & 255];
            cmd_ready = 1'b1;
            #1;
            if (stall_cmd && stalls < 4 && cmd_valid && fid == 10'h003) begin
                cmd_ready = 1'b0;
                stalls++;
            end
            res_ready = !(hold_res && hold < 5);
            #1;
            if (op_ready) opr++;
            if (op_valid && op_ready) idx++;
            if (res_valid) begin
                if (lat == 0) begin lat = cyc; first = res_data; end
                if (!res_ready) begin
                    hold++;
                    check("res_stable", res_data, first);
                    check("job_ready_in_done", {31'h0, job_ready}, 32'd0);
                end else begin
                    res  = res_data;
                    done = 1'b1;
                end
            end
        end
        check("job_done", {31'h0, done}, 32'd1);
        check("ops_consumed", idx, len);
        if (done) exp_jobs++;
        @(negedge clk);
        op_valid = 1'b0; res_ready = 1'b1;
        #1;
        check("job_ready_after", {31'h0, job_ready}, 32'd1);
        check("jobs_done", {16'h0, jobs_done}, exp_jobs);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        int lat, opr, seen, rv;
        rst_n = 1'b0; job_valid = 1'b0; job_offset = 32'h0; job_len = 8'h0;
        op_valid = 1'b0; op_data = 16'h0; res_ready = 1'b1; cmd_ready = 1'b1;
        tog_op = 1'b0; stall_cmd = 1'b0; hold_res = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_job_ready", {31'h0, job_ready}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_res_valid", {31'h0, res_valid}, 32'd0);
        check("rst_cmd_valid", {31'h0, cmd_valid}, 32'd0);
        check("rst_rsp_ready", {31'h0, rsp_ready}, 32'd0);
        check("rst_op_ready", {31'h0, op_ready}, 32'd0);
        check("rst_jobs_done", {16'h0, jobs_done}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_job_ready", {31'h0, job_ready}, 32'd1);

        // offset 128: 0 + (-28) + 765
        ops[0] = {8'd2, 8'h80}; ops[1] = {8'hFF, 8'h9C}; ops[2] = {8'd3, 8'd127};
        run_job(32'd128, 3, res, lat, opr);
        check("j1_result", res, 32'd737);
        check("j1_latency", lat, 32'd11);
        check("j1_op_ready", opr, 32'd3);

        run_job(32'd5, 0, res, lat, opr);
        check("j2_result", res, 32'd0);
        check("j2_latency", lat, 32'd5);
        check("j2_op_ready", opr, 32'd0);
        check("j2_ncmd", cmd_log.size(), 32'd2);
        check("j2_cmd0", {22'h0, cmd_log[0]}, 32'h013);
        check("j2_cmd1", {22'h0, cmd_log[1]}, 32'h00B);

        for (int i = 0; i < 256; i++) ops[i] = {8'd127, 8'd127};
        run_job(32'd0, 255, res, lat, opr);
        check("j3_result", res, 32'd4112895);
        check("j3_latency", lat, 32'd515);

        // offset 3: 4 - 16 + 0 - 70 - 161 = -243
        ops[0] = {8'd1, 8'd1}; ops[1] = {8'hFE, 8'd5}; ops[2] = {8'd4, 8'hFD};
        ops[3] = {8'd10, 8'hF6}; ops[4] = {8'hF9, 8'd20};
        tog_op = 1'b1; stall_cmd = 1'b1;
        run_job(32'd3, 5, res, lat, opr);
        tog_op = 1'b0; stall_cmd = 1'b0;
        check("j4_result", res, 32'hFFFF_FF0D);
        check("j4_ncmd", cmd_log.size(), 32'd7);

        ops[0] = {8'd5, 8'd6};
        hold_res = 1'b1;
        run_job(32'd1, 1, res, lat, opr);
        hold_res = 1'b0;
        check("j5_result", res, 32'd35);

        // abandon a len=4 job during its second accumulate response
        for (int i = 0; i < 4; i++) ops[i] = {8'd1, 8'd1};
        @(negedge clk);
        job_valid = 1'b1; job_offset = 32'h10; job_len = 8'd4;
        @(negedge clk);
        job_valid = 1'b0;
        seen = 0; rv = 0;
        for (int c = 0, idx = 0; c < 100 && seen < 2; c++) begin
            @(negedge clk);
            op_valid = (idx < 4);
            op_data  = ops[idx & 3];
            #1;
            if (op_valid && op_ready) idx++;
            if (res_valid) rv++;
            if (rsp_ready && cmd_log.size() > 0 && cmd_log[$] == 10'h003) seen++;
        end
        check("abort_reached", seen, 32'd2);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_job_ready", {31'h0, job_ready}, 32'd0);
        check("abort_rsp_ready", {31'h0, rsp_ready}, 32'd0);
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (res_valid) rv++;
        end
        check("abort_no_res", rv, 32'd0);
        check("abort_jobs_done", {16'h0, jobs_done}, 32'd0);
        exp_jobs = 0;

        ops[0] = {8'd3, 8'd4};
        run_job(32'd0, 1, res, lat, opr);
        check("j6_result", res, 32'd12);
        check("j6_cmd0", {22'h0, cmd_log[0]}, 32'h013);
        check("j6_cmd1", {22'h0, cmd_log[1]}, 32'h00B);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cfu_mac_sequencer.md
CFU_MAC_SEQUENCER -- requirements
Module: cfu_mac_sequencer

Interface
REQ-001 Parameter LEN_W, default 8, width of job length; maximum job is 2^LEN_W-1 accumulate steps.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; assertion clears state immediately, deassertion is sampled on clk.
REQ-004 job_valid / job_ready  input / output  1 / 1  job handshake; a job is accepted when both are high on a clk edge.
REQ-005 job_offset  input  32  input offset programmed into the MAC for this job.
REQ-006 job_len  input  LEN_W  number of operand pairs to accumulate; 0 is legal.
REQ-007 op_valid / op_ready  input / output  1 / 1  operand stream handshake.
REQ-008 op_data  input  16  [15:8] signed filter byte, [7:0] signed input byte.
REQ-009 res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-010 res_data  output  32  accumulated dot product, two's complement.
REQ-011 cfu_cmd_valid / cfu_cmd_ready  output / input  1 / 1  MAC command handshake.
REQ-012 cfu_function_id  output  10  MAC command code.
REQ-013 cfu_inputs_0 / cfu_inputs_1  output / output  32 / 32  MAC operands.
REQ-014 cfu_rsp_valid / cfu_rsp_ready  input / output  1 / 1  MAC response handshake.
REQ-015 cfu_rsp_data  input  32  MAC response payload.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 jobs_done  output  16  count of completed results, wraps at 2^16.

Function
REQ-018 The FSM SHALL have states IDLE, OFS_CMD, OFS_RSP, CLR_CMD, CLR_RSP, ACC_CMD, ACC_RSP, DONE.
REQ-019 The FSM SHALL keep at most one MAC command outstanding; a new command is never issued until the previous response has been handshaken.
REQ-020 IDLE: job_ready=1; on job handshake, latch job_offset, load remaining counter with job_len, and go to OFS_CMD.
REQ-021 OFS_CMD: cfu_cmd_valid=1, function_id=10'h013 (set offset), inputs_0=latched offset, inputs_1=0; on cmd handshake go to OFS_RSP.
REQ-022 CLR_CMD: cfu_cmd_valid=1, function_id=10'h00B (clear), inputs 0; on cmd handshake go to CLR_RSP.
REQ-023 ACC_CMD: cfu_cmd_valid=op_valid; op_ready=cfu_cmd_ready; function_id=10'h003; inputs_0={24'b0,op_data[15:8]}; inputs_1={24'b0,op_data[7:0]}; on handshake decrement remaining and go to ACC_RSP.
REQ-024 *_RSP states: cfu_rsp_ready=1; on rsp handshake capture cfu_rsp_data into the result register (OFS_RSP excepted) and advance: OFS_RSP->CLR_CMD; CLR_RSP->DONE if remaining==0, else ACC_CMD; ACC_RSP->DONE if remaining==0, else ACC_CMD.
REQ-025 cfu_rsp_ready SHALL be 0 outside *_RSP states; op_ready SHALL be 0 outside ACC_CMD.
REQ-026 DONE: res_valid=1, res_data=result register, held stable until res_ready; on handshake increment jobs_done and go to IDLE.
REQ-027 The offset SHALL be reprogrammed on every job, because the MAC's offset register is not reset.
REQ-028 Accumulation wraps modulo 2^32 inside the MAC; the sequencer passes the response through unmodified.
REQ-029 With a MAC that responds one cycle after cmd and ready partners, each command costs exactly 2 cycles; res_valid asserts 2*(job_len+2)+1 cycles after the job handshake.
REQ-030 Stalls on cmd_ready, op_valid or rsp_valid SHALL extend the current state with no effect on counters or outputs.

Reset
REQ-031 While reset is low: state=IDLE, remaining=0, result=0, jobs_done=0, and all valid/ready outputs=0 except job_ready (0 during reset, 1 in IDLE after release).
REQ-032 Reset mid-job SHALL abandon the job; no res_valid SHALL be produced for it, and the next job reprograms the offset and clears the MAC.

Verification
REQ-033 offset=128, len=3, pairs (f,in)=(2,-128),(-1,-100),(3,127) -> res_data=737 (0+(-28)+765), jobs_done=1.
REQ-034 len=0, offset=5 -> commands issued are set-offset then clear only; res_data=0; no op_ready pulse.
REQ-035 offset=0, len=255, all pairs (127,127) -> res_data=4112895.
REQ-036 cfu_cmd_ready held low 4 cycles in ACC_CMD and op_valid toggled -> no lost or duplicated pair; result matches the reference sum.
REQ-037 res_ready held low 5 cycles in DONE -> res_data stable, job_ready=0; after handshake job_ready=1.
REQ-038 reset pulsed low during the 2nd ACC_RSP of a len=4 job -> busy=0 immediately, no res_valid; next job offset=0, len=1, (3,4) -> res_data=12.
